cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, 256, width in bits of one cache line on every data bus.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_read  input  1  instruction-cache line-read request.
REQ-005 i_address  input  32  instruction line address.
REQ-006 i_rdata  output  LINE_WIDTH  line returned to the instruction cache.
REQ-007 i_resp  output  1  instruction transaction complete.
REQ-008 d_read  input  1  data-cache line-read request.
REQ-009 d_write  input  1  data-cache line-writeback request.
REQ-010 d_address  input  32  data line address.
REQ-011 d_wdata  input  LINE_WIDTH  writeback line.
REQ-012 d_rdata  output  LINE_WIDTH  line returned to the data cache.
REQ-013 d_resp  output  1  data transaction complete.
REQ-014 m_read, m_write  output  1 each  downstream memory read and write strobes.
REQ-015 m_address  output  32  downstream address.
REQ-016 m_wdata  output  LINE_WIDTH  downstream write line.
REQ-017 m_rdata  input  LINE_WIDTH  downstream read line.
REQ-018 m_resp  input  1  downstream transaction complete.

Function
REQ-019 FSM states SHALL be IDLE, SERV_I and SERV_D; reset state IDLE.
REQ-020 IDLE: pending = i_read for I, (d_read|d_write) for D; a sole pending requester SHALL be granted, moving to its SERV state next cycle.
REQ-021 IDLE, both pending: the requester not granted last SHALL win; a last_grant register SHALL reset to I, so D wins the first contention after reset.
REQ-022 On grant SHALL register address, operation (read/write; d_write overrides d_read if both set) and d_wdata; downstream outputs SHALL come only from these registers, so later requester-bus changes have no effect.
REQ-023 SERV_I: m_read=1, m_write=0, m_address=latched i address.
REQ-024 SERV_D: exactly one of m_read/m_write=1 per latched op; m_address=latched d address; m_wdata=latched line.
REQ-025 In SERV_x with m_resp=1: x_resp=1 in the same cycle (combinational); for a read, x_rdata=m_rdata in that cycle; state SHALL return to IDLE next cycle and last_grant SHALL update to x.
REQ-026 Unserved requester's resp SHALL stay 0; i_rdata/d_rdata SHALL be m_rdata when not qualified by resp (value don't-care).
REQ-027 Outside SERV states m_read=m_write=0, i_resp=d_resp=0; m_resp in IDLE SHALL be ignored.
REQ-028 Request-to-strobe latency SHALL be exactly 1 cycle from IDLE; a minimum of one IDLE cycle SHALL separate consecutive transactions.
REQ-029 Requesters hold request and operands until their resp; a request dropped mid-service SHALL NOT abort the downstream transaction.
REQ-030 Each x_resp SHALL be a single-cycle pulse per transaction; a downstream transaction SHALL never be issued twice for one grant.
REQ-031 Latched registers and state SHALL be at most 2*32+LINE_WIDTH+4 flops; no combinational path from any requester input to m_* outputs.

Reset
REQ-032 rst SHALL force IDLE, last_grant=I, clear latched op, and drive m_read=m_write=i_resp=d_resp=0 the next cycle, including mid-transaction; an outstanding downstream transaction is abandoned.

Verification
REQ-033 i_read=1, i_address=0x0000_0040 alone; m_resp after 3 cycles with m_rdata=0xA5.. -> m_read high 1 cycle after request, m_address=0x40, i_resp 1-cycle pulse with i_rdata=0xA5.., d_resp=0.
REQ-034 After reset, i_read and d_write (0x1000) both at the same cycle -> D served first (m_write, m_address=0x1000), then after one IDLE cycle I served.
REQ-035 Continuous contention over 4 transactions -> grants alternate D,I,D,I; no back-to-back same requester.
REQ-036 d_address changed to 0xDEAD_0000 during SERV_D -> m_address stays original latched value until d_resp.
REQ-037 rst asserted during SERV_I before m_resp -> next cycle m_read=0, no i_resp; late m_resp ignored; fresh i_read served normally.
REQ-038 d_read=d_write=1 -> m_write=1, m_read=0.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: requester and memory-side buses of the cache arbiter.
// slave = arbiter view, master = caches plus memory view.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [31:0]           i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [31:0]           d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  m_read;
  logic                  m_write;
  logic [31:0]           m_address;
  logic [LINE_WIDTH-1:0] m_wdata;
  logic [LINE_WIDTH-1:0] m_rdata;
  logic                  m_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output m_read, m_write, m_address, m_wdata,
    input  m_rdata, m_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  m_read, m_write, m_address, m_wdata,
    output m_rdata, m_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory port between I and D caches.
// Alternating priority on contention; operands latched at grant.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERV_I,
    SERV_D
  } state_t;

  state_t                state;
  logic                  last_d;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  m_read_q;
  logic                  m_write_q;

  logic i_pend;
  logic d_pend;
  logic grant_i;
  logic grant_d;

  // D wins unless I is also pending and D was served last
  always_comb begin
    i_pend  = bus.i_read;
    d_pend  = bus.d_read | bus.d_write;
    grant_d = d_pend & (~i_pend | ~last_d);
    grant_i = i_pend & ~grant_d;
  end

  // arbitration FSM; strobes and operands captured at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              state     <= SERV_D;
              addr_q    <= bus.d_address;
              wdata_q   <= bus.d_wdata;
              m_read_q  <= ~bus.d_write;
              m_write_q <= bus.d_write;
            end
            grant_i: begin
              state     <= SERV_I;
              addr_q    <= bus.i_address;
              m_read_q  <= 1'b1;
              m_write_q <= 1'b0;
            end
            default: ;
          endcase
        end
        SERV_I: begin
          if (bus.m_resp) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
          end
        end
        SERV_D: begin
          if (bus.m_resp) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_read    = m_read_q;
  assign bus.m_write   = m_write_q;
  assign bus.m_address = addr_q;
  assign bus.m_wdata   = wdata_q;

  assign bus.i_resp  = (state == SERV_I) & bus.m_resp;
  assign bus.d_resp  = (state == SERV_D) & bus.m_resp;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule
